gauss_blur_engine: RTL and testbench

GAUSS_BLUR_ENGINE -- requirements
Module: gauss_blur_engine

---
 rtl/blur_pkg.sv | 29 ++
 rtl/blur_addr_gen.sv | 31 +++
 rtl/gauss_blur_engine.sv | 114 +++++++++++
 tb/tb_gauss_blur_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/blur_pkg.sv
// Shared defaults, FSM state encoding and 3x3 Gaussian kernel weights.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package blur_pkg;

  localparam int IMG_W_DEF  = 5;
  localparam int IMG_H_DEF  = 5;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int PIX_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LAST  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Row-major 3x3 window: corners weigh 1, edge-adjacent taps 2, centre 4.
  function automatic logic [2:0] tap_weight(input logic [3:0] tap);
    case (tap)
      4'd4:                      tap_weight = 3'd4;
      4'd1, 4'd3, 4'd5, 4'd7:    tap_weight = 3'd2;
      default:                   tap_weight = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/blur_addr_gen.sv
// Maps (pixel index, window tap) to the linear address of the clamped neighbour.
// Latency: purely combinational.
// Backpressure: not applicable.
module blur_addr_gen
  import blur_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pix_idx,
  input  logic [3:0]        tap,
  output logic [ADDR_W-1:0] addr
);

  int row, col, nr, nc;

  // Offset the centre pixel by the tap's (row, col) delta, replicating edge pixels.
  always_comb begin
    row  = int'(pix_idx) / IMG_W;
    col  = int'(pix_idx) % IMG_W;
    nr   = row + int'(tap) / 3 - 1;
    nc   = col + int'(tap) % 3 - 1;
    if (nr < 0)      nr = 0;
    if (nr >= IMG_H) nr = IMG_H - 1;
    if (nc < 0)      nc = 0;
    if (nc >= IMG_W) nc = IMG_W - 1;
    addr = ADDR_W'(nr * IMG_W + nc);
  end

endmodule

// File: rtl/gauss_blur_engine.sv
// 3x3 Gaussian blur over a whole image read from a synchronous-read pixel memory.
// Latency: first pixel 10 cycles after start; 11 cycles per pixel with out_ready high.
// Backpressure: EMIT holds pix_out/pix_idx/pix_valid until out_ready; no fetch while held.
module gauss_blur_engine
  import blur_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic [ADDR_W-1:0] pix_idx,
  output logic              pix_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Weighted sum peaks at 16*(2**PIX_W-1); +8 rounding still fits in PIX_W+4 bits.
  localparam int ACC_W = PIX_W + 4;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        tap;
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] tap_addr;
  logic [3:0]        data_tap;
  logic [ACC_W-1:0]  addend, acc_sum, rounded;
  logic              unused_hi;

  blur_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .pix_idx (idx),
    .tap     (tap),
    .addr    (tap_addr)
  );

  // Read data lags the address by one cycle, so FETCH accumulates the previous
  // tap and LAST accumulates tap 8 itself.
  assign data_tap  = (state == LAST) ? tap : tap - 4'd1;
  assign addend    = ACC_W'(tap_weight(data_tap)) * ACC_W'(mem_rdata[PIX_W-1:0]);
  assign acc_sum   = acc + addend;
  assign rounded   = acc_sum + ACC_W'(8);
  assign unused_hi = ^mem_rdata[DATA_W-1:PIX_W];

  assign mem_addr  = (state == FETCH) ? tap_addr : '0;
  assign pix_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (tap == 4'd8) state_nxt = LAST;
      LAST:    state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel/tap counters, accumulator and registered output pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      tap     <= '0;
      acc     <= '0;
      pix_out <= '0;
      pix_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
            tap <= '0;
            acc <= '0;
          end
        end
        FETCH: begin
          if (tap != 4'd0) acc <= acc_sum;
          if (tap != 4'd8) tap <= tap + 4'd1;
        end
        LAST: begin
          pix_out <= rounded[ACC_W-1:4];
          pix_idx <= idx;
        end
        EMIT: begin
          if (out_ready && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
            tap <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_blur_engine.sv
// Self-checking bench for gauss_blur_engine against a clamped-convolution reference.
// Latency: checks first-pixel, per-pixel and done timing in cycles from start.
// Backpressure: drives fixed and random out_ready stalls and checks held outputs.
module tb_gauss_blur_engine;

  localparam int W = 5, H = 5, AW = 5, DW = 32, PW = 8, NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [PW-1:0] pix_out;
  logic [AW-1:0] pix_idx;
  logic          pix_valid, busy, done;

  logic [DW-1:0] mem [0:31];
  int            got [0:NPIX-1];
  int            n_checks = 0;
  int            n_pass = 0;
  int            done_cnt = 0;

  gauss_blur_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .pix_out   (pix_out),
    .pix_idx   (pix_idx),
    .pix_valid (pix_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel memory.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Count done pulses over the whole run.
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: weighted sum over the replicated-border 3x3 neighbourhood.
  function automatic int ref_pix(input int k);
    int r, c, rr, cc, sum;
    r = k / W;
    c = k % W;
    sum = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = (r + dr < 0) ? 0 : ((r + dr > H - 1) ? H - 1 : r + dr);
        cc = (c + dc < 0) ? 0 : ((c + dc > W - 1) ? W - 1 : c + dc);
        sum += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * int'(mem[rr * W + cc][PW-1:0]);
      end
    end
    return (sum + 8) / 16;
  endfunction

  task automatic fill(input int mode, input int val);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0: mem[i] = DW'(val);
        1: mem[i] = {24'hFFFFFF, 8'(val)};
        2: mem[i] = $urandom;
        default: mem[i] = '0;
      endcase
    end
  endtask

  // One frame: pulse start, then check every output, its timing and the done pulse.
  task automatic run_frame(input int bp_idx, input int rnd_ready, input int dup_start_cyc);
    int k, cyc, next_exp, held, stall, last_acc, seen_done, d0;
    int hold_out, hold_idx;
    k = 0; cyc = 0; next_exp = 10; held = 0; stall = 0; last_acc = -1; seen_done = 0;
    hold_out = 0; hold_idx = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000 && seen_done == 0) begin
      if (held != 0) begin
        check_eq("hold_valid", int'(pix_valid), 1);
        check_eq("hold_out", int'(pix_out), hold_out);
        check_eq("hold_idx", int'(pix_idx), hold_idx);
        check_eq("hold_addr", int'(mem_addr), 0);
      end
      if (done) begin
        seen_done = 1;
        check_eq("done_time", cyc, last_acc);
        check_eq("done_count_pix", k, NPIX);
      end else if (pix_valid) begin
        if (held == 0) begin
          check_eq("pix_time", cyc, next_exp);
          check_eq("pix_idx", int'(pix_idx), k);
          check_eq("pix_val", int'(pix_out), ref_pix(k));
          if (k < NPIX) got[k] = int'(pix_out);
        end
        if (k == bp_idx && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else if (rnd_ready != 0) begin
          out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          out_ready = 1'b1;
        end
        held = out_ready ? 0 : 1;
        hold_out = int'(pix_out);
        hold_idx = int'(pix_idx);
        if (out_ready) begin
          last_acc = cyc + 1;
          next_exp = cyc + 11;
          k++;
        end
      end else begin
        held = 0;
      end
      start = (cyc == dup_start_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (seen_done == 0) check_eq("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check_eq("single_done", done_cnt - d0, 1);
    check_eq("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int found;
    int d0;

    fill(3, 0);
    #12;
    check_eq("rst_pix_out", int'(pix_out), 0);
    check_eq("rst_pix_idx", int'(pix_idx), 0);
    check_eq("rst_valid", int'(pix_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flat image.
    fill(0, 100);
    run_frame(-1, 0, -1);
    check_eq("flat_last", got[24], 100);

    // Impulse at the centre.
    fill(3, 0);
    mem[12] = 32'd160;
    run_frame(-1, 0, -1);
    check_eq("imp_12", got[12], 40);
    check_eq("imp_7", got[7], 20);
    check_eq("imp_17", got[17], 20);
    check_eq("imp_6", got[6], 10);
    check_eq("imp_18", got[18], 10);
    check_eq("imp_0", got[0], 0);

    // Corner impulse exercising border replication.
    fill(3, 0);
    mem[0] = 32'd255;
    run_frame(-1, 0, -1);
    check_eq("cor_0", got[0], 143);
    check_eq("cor_1", got[1], 48);
    check_eq("cor_5", got[5], 48);
    check_eq("cor_6", got[6], 16);

    // Five-cycle stall on index 3 with random pixels.
    fill(2, 0);
    run_frame(3, 0, -1);

    // Asynchronous reset in the middle of index 10.
    fill(2, 0);
    d0 = done_cnt;
    found = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (pix_valid && pix_idx == AW'(10)) found = 1;
      else @(negedge clk);
    end
    check_eq("rst_reach_idx10", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_pix_out", int'(pix_out), 0);
    check_eq("arst_pix_idx", int'(pix_idx), 0);
    check_eq("arst_valid", int'(pix_valid), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_done", int'(done), 0);
    check_eq("arst_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("arst_no_done", done_cnt - d0, 0);
    run_frame(-1, 0, -1);

    // Flat image with garbage upper bits and a start pulse while busy.
    fill(1, 100);
    run_frame(-1, 0, 50);
    check_eq("hi_bits_first", got[0], 100);
    check_eq("hi_bits_last", got[24], 100);

    // Random image under random backpressure.
    fill(2, 0);
    run_frame(-1, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
